// File: rtl/sample_recorder.sv
// sample_recorder: arms on request, starts capturing 8-bit offset-binary
// samples into a single-port RAM once the input leaves the threshold band
// around MID, and stops on request or when the RAM fills. The number of
// samples captured is published on `length` for the playback side.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for arm; stop ignored
// S_ARMED  | waiting for a tick with |din - MID| >= THRESH
// S_RECORD | every tick is written; ends on stop or a write to the last address
// S_DONE   | one cycle: publish length, pulse done
module sample_recorder #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int MID    = 128,
  parameter int THRESH = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] din,
  input  logic              arm,
  input  logic              stop,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              full
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_RECORD = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [DATA_W:0] MID_X = (DATA_W+1)'(MID);
  localparam logic [DATA_W:0] THR_X = (DATA_W+1)'(THRESH);
  localparam logic [ADDR_W:0] LAST  = {1'b0, {ADDR_W{1'b1}}};

  logic [1:0]        state;
  logic [ADDR_W:0]   ptr;
  logic [DATA_W:0]   din_x;
  logic [DATA_W:0]   mag;
  logic [DATA_W+1:0] thr_diff;
  logic              trig;
  logic              wr_req;
  logic              wr_last;

  // Amplitude above threshold and write qualification for this cycle.
  // The threshold test is done as a widened subtraction so that THRESH=0
  // still elaborates to a live compare (every tick qualifies).
  always_comb begin
    din_x    = {1'b0, din};
    mag      = (din_x >= MID_X) ? (din_x - MID_X) : (MID_X - din_x);
    thr_diff = {1'b0, mag} - {1'b0, THR_X};
    trig     = ~thr_diff[DATA_W+1];
    wr_req   = ((state == S_ARMED) && sample_tick && trig && !stop) ||
               ((state == S_RECORD) && sample_tick);
    wr_last  = wr_req && (ptr == LAST);
  end

  // Registered RAM write port and the write pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ram_addr <= '0;
      ram_data <= '0;
      ram_wren <= 1'b0;
      ptr      <= '0;
    end else begin
      ram_wren <= wr_req;
      if (wr_req) begin
        ram_addr <= ptr[ADDR_W-1:0];
        ram_data <= din;
        ptr      <= ptr + 1'b1;
      end else if ((state == S_IDLE) && arm) begin
        ptr <= '0;
      end
    end
  end

  // Recording sequencer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (arm) state <= S_ARMED;
        S_ARMED: begin
          if (stop)         state <= S_IDLE;
          else if (wr_last) state <= S_DONE;
          else if (wr_req)  state <= S_RECORD;
        end
        S_RECORD: if (wr_last || stop) state <= S_DONE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Published length and the RAM-full flag; both survive until replaced.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      length <= '0;
      full   <= 1'b0;
    end else begin
      if (state == S_DONE) length <= ptr;
      if ((state == S_IDLE) && arm) full <= 1'b0;
      else if (wr_last)             full <= 1'b1;
    end
  end

  // Status decode straight from the state register so reset clears it at once.
  always_comb begin
    busy = (state == S_ARMED) || (state == S_RECORD);
    done = (state == S_DONE);
  end

endmodule

// File: tb/tb_sample_recorder.sv
module tb_sample_recorder;

  localparam int AW   = 13;
  localparam int DW   = 8;
  localparam int MIDV = 128;
  localparam int THR  = 8;
  localparam int AWS  = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic          tick, arm, stop;
  logic [DW-1:0] din;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [AW:0]   length;
  logic          busy, done, full;

  logic           tick_s, arm_s, stop_s;
  logic [DW-1:0]  din_s;
  logic [AWS-1:0] s_addr;
  logic [DW-1:0]  s_data;
  logic           s_wren;
  logic [AWS:0]   s_length;
  logic           s_busy, s_done, s_full;

  sample_recorder #(.ADDR_W(AW), .DATA_W(DW), .MID(MIDV), .THRESH(THR)) dut (
    .clk(clk), .resetn(resetn), .sample_tick(tick), .din(din), .arm(arm), .stop(stop),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .length(length), .busy(busy), .done(done), .full(full));

  sample_recorder #(.ADDR_W(AWS), .DATA_W(DW), .MID(MIDV), .THRESH(0)) dut_s (
    .clk(clk), .resetn(resetn), .sample_tick(tick_s), .din(din_s), .arm(arm_s), .stop(stop_s),
    .ram_addr(s_addr), .ram_data(s_data), .ram_wren(s_wren),
    .length(s_length), .busy(s_busy), .done(s_done), .full(s_full));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       arm, stop, tick;
    logic [7:0] din;
    logic       wren;
    int         addr, data;
    logic       busy, done;
    int         len;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic a, input logic s, input logic t, input int d,
                               input logic w, input int ad, input int dt,
                               input logic b, input logic dn, input int l);
    vec_t r;
    r.arm = a; r.stop = s; r.tick = t; r.din = d[7:0];
    r.wren = w; r.addr = ad; r.data = dt; r.busy = b; r.done = dn; r.len = l;
    return r;
  endfunction

  // Reference model: a recording is a list of captured samples.
  logic   m_armed, m_rec, m_fin, m_full;
  byte    rec[$];
  int     m_len;
  logic   e_wren;
  int     e_addr, e_data;

  task automatic model_reset();
    m_armed = 0; m_rec = 0; m_fin = 0; m_full = 0; m_len = 0;
    rec.delete();
    e_wren = 0; e_addr = 0; e_data = 0;
  endtask

  task automatic model_step(input logic a, input logic s, input logic t, input int d);
    int mag;
    mag = d - MIDV;
    if (mag < 0) mag = -mag;
    e_wren = 0;
    if (m_fin) begin
      m_len = rec.size();
      m_fin = 0;
    end else if (m_armed) begin
      if (s) m_armed = 0;
      else if (t && mag >= THR) begin
        e_wren = 1; e_addr = rec.size(); e_data = d;
        rec.push_back(byte'(d));
        m_armed = 0; m_rec = 1;
      end
    end else if (m_rec) begin
      if (t) begin
        e_wren = 1; e_addr = rec.size(); e_data = d;
        rec.push_back(byte'(d));
      end
      if (rec.size() == (1 << AW)) m_full = 1;
      if (s || rec.size() == (1 << AW)) begin
        m_rec = 0; m_fin = 1;
      end
    end else if (a) begin
      m_armed = 1; m_full = 0;
      rec.delete();
    end
  endtask

  task automatic idle_inputs();
    arm = 0; stop = 0; tick = 0; din = 0;
    arm_s = 0; stop_s = 0; tick_s = 0; din_s = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nwr, ndone;
    idle_inputs();
    resetn = 0;
    #1;
    chk("rst addr", ram_addr, 0);
    chk("rst data", ram_data, 0);
    chk("rst wren", ram_wren, 0);
    chk("rst length", length, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst full", full, 0);
    do_reset();

    // Directed table: threshold, back-to-back, stop alone, stop+tick, abort/ignore.
    vecs.push_back(mkv(1,0,0,  0, 0,0,  0, 1,0,0));
    vecs.push_back(mkv(0,0,1,130, 0,0,  0, 1,0,0));
    vecs.push_back(mkv(0,0,1,124, 0,0,  0, 1,0,0));
    vecs.push_back(mkv(0,0,1,140, 1,0,140, 1,0,0));
    vecs.push_back(mkv(0,0,1, 50, 1,1, 50, 1,0,0));
    vecs.push_back(mkv(0,0,0,  0, 0,0,  0, 1,0,0));
    vecs.push_back(mkv(0,0,1, 10, 1,2, 10, 1,0,0));
    vecs.push_back(mkv(0,0,1, 20, 1,3, 20, 1,0,0));
    vecs.push_back(mkv(0,0,1, 30, 1,4, 30, 1,0,0));
    vecs.push_back(mkv(0,0,1, 40, 1,5, 40, 1,0,0));
    vecs.push_back(mkv(0,0,0,  0, 0,0,  0, 1,0,0));
    vecs.push_back(mkv(0,1,0,  0, 0,0,  0, 0,1,0));
    vecs.push_back(mkv(0,0,0,  0, 0,0,  0, 0,0,6));
    vecs.push_back(mkv(1,0,0,  0, 0,0,  0, 1,0,6));
    vecs.push_back(mkv(0,0,1,200, 1,0,200, 1,0,6));
    vecs.push_back(mkv(0,0,1, 60, 1,1, 60, 1,0,6));
    vecs.push_back(mkv(1,0,0,  0, 0,0,  0, 1,0,6));
    vecs.push_back(mkv(0,0,1,128, 1,2,128, 1,0,6));
    vecs.push_back(mkv(0,1,1, 99, 1,3, 99, 0,1,6));
    vecs.push_back(mkv(0,0,0,  0, 0,0,  0, 0,0,4));
    vecs.push_back(mkv(1,0,0,  0, 0,0,  0, 1,0,4));
    vecs.push_back(mkv(1,0,0,  0, 0,0,  0, 1,0,4));
    vecs.push_back(mkv(0,1,0,  0, 0,0,  0, 0,0,4));
    vecs.push_back(mkv(0,0,0,  0, 0,0,  0, 0,0,4));
    vecs.push_back(mkv(1,1,0,  0, 0,0,  0, 1,0,4));
    vecs.push_back(mkv(0,0,1,128, 0,0,  0, 1,0,4));
    vecs.push_back(mkv(0,1,1,200, 0,0,  0, 0,0,4));
    vecs.push_back(mkv(0,0,0,  0, 0,0,  0, 0,0,4));

    for (int i = 0; i < vecs.size(); i++) begin
      arm = vecs[i].arm; stop = vecs[i].stop; tick = vecs[i].tick; din = vecs[i].din;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d wren", i), ram_wren, vecs[i].wren);
      if (vecs[i].wren) begin
        chk($sformatf("vec%0d addr", i), ram_addr, vecs[i].addr);
        chk($sformatf("vec%0d data", i), ram_data, vecs[i].data);
      end
      chk($sformatf("vec%0d busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d done", i), done, vecs[i].done);
      chk($sformatf("vec%0d length", i), length, vecs[i].len);
    end
    idle_inputs();
    chk("table full", full, 0);

    // Async reset in the middle of a recording after 5 writes.
    arm = 1; @(posedge clk); #1; arm = 0;
    for (int i = 0; i < 5; i++) begin
      tick = 1; din = 8'(150 + i);
      @(posedge clk); #1;
    end
    tick = 0;
    chk("pre-reset busy", busy, 1);
    chk("pre-reset addr", ram_addr, 4);
    #2 resetn = 0;
    #1;
    chk("midrst addr", ram_addr, 0);
    chk("midrst data", ram_data, 0);
    chk("midrst wren", ram_wren, 0);
    chk("midrst length", length, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst full", full, 0);
    @(negedge clk);
    resetn = 1;
    tick = 1; din = 200;
    @(posedge clk); #1;
    tick = 0;
    chk("postrst wren", ram_wren, 0);
    chk("postrst busy", busy, 0);
    chk("postrst length", length, 0);

    // Fill the small RAM: 20 ticks, only 16 land.
    nwr = 0; ndone = 0;
    arm_s = 1; @(posedge clk); #1; arm_s = 0;
    for (int i = 0; i < 24; i++) begin
      tick_s = (i < 20);
      din_s  = 8'(50 + i);
      @(posedge clk); #1;
      if (s_wren) begin
        chk($sformatf("fill addr%0d", nwr), s_addr, nwr);
        chk($sformatf("fill data%0d", nwr), s_data, 50 + nwr);
        nwr++;
      end
      if (s_done) ndone++;
    end
    tick_s = 0;
    chk("fill writes", nwr, 16);
    chk("fill done pulses", ndone, 1);
    chk("fill full", s_full, 1);
    chk("fill length", s_length, 16);
    chk("fill busy", s_busy, 0);
    arm_s = 1; @(posedge clk); #1; arm_s = 0;
    chk("rearm full clr", s_full, 0);
    chk("rearm length held", s_length, 16);
    chk("rearm busy", s_busy, 1);
    stop_s = 1; @(posedge clk); #1; stop_s = 0;
    chk("rearm abort busy", s_busy, 0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int d;
      arm  = ($urandom_range(0, 5) == 0);
      stop = ($urandom_range(0, 39) == 0);
      tick = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) d = $urandom_range(118, 138);
      else d = $urandom_range(0, 255);
      din = 8'(d);
      model_step(arm, stop, tick, d);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d wren", c), ram_wren, e_wren);
      if (e_wren) begin
        chk($sformatf("rnd%0d addr", c), ram_addr, e_addr);
        chk($sformatf("rnd%0d data", c), ram_data, e_data);
      end
      chk($sformatf("rnd%0d busy", c), busy, m_armed | m_rec);
      chk($sformatf("rnd%0d done", c), done, m_fin);
      chk($sformatf("rnd%0d length", c), length, m_len);
      chk($sformatf("rnd%0d full", c), full, m_full);
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_recorder.md
Name: sample_recorder

Overview:
Write-side counterpart to the drum sample player. It captures a stream of 8-bit offset-binary audio samples into a single-port sample RAM. The RAM is the same depth and width as the kick/snare/hat/clap ROMs, so a recorded sample can later be played back through the same 13-bit address counter.
Recording is armed by the user and starts automatically when the input crosses an amplitude threshold. It ends on stop or when the RAM fills, and the recorded length is reported to the playback side.

Parameters:
ADDR_W, 13, RAM address width; depth = 2^ADDR_W samples
DATA_W, 8, sample width (offset binary)
MID, 128, zero-level code of the input
THRESH, 8, trigger threshold on |din - MID|; 0 = trigger on first tick

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
sample_tick  in  1  one-cycle strobe: din valid this cycle
din  in  DATA_W  input sample
arm  in  1  one-cycle request to arm a new recording
stop  in  1  one-cycle request to end/abort
ram_addr  out  ADDR_W  RAM write address (registered)
ram_data  out  DATA_W  RAM write data (registered)
ram_wren  out  1  RAM write enable, one cycle per sample
length  out  ADDR_W+1  samples in last completed recording (0..2^ADDR_W)
busy  out  1  high in ARMED or RECORD
done  out  1  one-cycle pulse on recording completion
full  out  1  last recording ended because RAM filled; cleared on arm

Behaviour:
- Reset (async, resetn=0):
  - state = IDLE, ptr = 0.
  - ram_addr = 0, ram_data = 0, ram_wren = 0.
  - length = 0, busy = 0, done = 0, full = 0.
  - Reset mid-recording discards the recording; length returns to 0.
- States: IDLE, ARMED, RECORD, DONE. busy = (state == ARMED or RECORD). done = (state == DONE).
- IDLE:
  - arm=1 -> ARMED; clear ptr and full.
  - stop is ignored, including when asserted together with arm.
- ARMED:
  - stop=1 -> IDLE. No write, no done pulse, length unchanged.
  - sample_tick=1 with |din-MID| >= THRESH -> the sample is written (write rule below) and the state becomes RECORD.
  - Ticks below threshold are discarded.
  - |din-MID| is computed unsigned, at DATA_W+1 bits, with no wrap.
  - Priority: stop beats a triggering tick in the same cycle.
- Write rule, on a qualifying tick at cycle t:
  - At edge t+1: ram_addr <= ptr, ram_data <= din, ram_wren <= 1, ptr <= ptr+1.
  - ram_wren is 0 in every cycle not following a write.
  - Latency is 1 cycle. Ticks on consecutive cycles are fully supported (one write per cycle).
- RECORD:
  - Every sample_tick writes; no threshold check.
  - stop alone -> DONE.
  - stop and sample_tick in the same cycle: the sample is written first, then -> DONE.
  - A write to address 2^ADDR_W-1 -> DONE on the same edge, full <= 1. Any simultaneous stop is redundant.
- DONE (exactly 1 cycle):
  - length <= ptr (the count of samples written).
  - done = 1, then -> IDLE.
  - The final write's ram_wren may be high in this same cycle.
  - Ticks, arm and stop during DONE are ignored.
- Held values:
  - length holds its value until the next DONE or reset; it is not cleared by arm.
  - While recording, the previous length stays visible.
- ptr is ADDR_W+1 bits wide, so a full RAM reports length = 2^ADDR_W (8192 at default).
- arm while busy is ignored (no restart).

Test Plan:
1. Reset: assert resetn=0 mid-RECORD after 5 writes -> all outputs 0 immediately (async). After release, the state is IDLE and length=0.
2. Threshold trigger (THRESH=8): arm, then ticks din=130, 124, 140, 50 -> no writes for 130 or 124. Writes follow at addr 0=140 and addr 1=50, each with ram_wren high exactly 1 cycle after its tick.
3. Back-to-back: in RECORD, ticks on 4 consecutive cycles with din 10, 20, 30, 40 -> ram_wren high 4 consecutive cycles, addr n..n+3, data 10..40.
4. Stop with tick: after 3 writes, stop and tick (din=99) in the same cycle -> addr 3=99 is written, done pulses for 1 cycle, length=4, full=0, busy falls.
5. Full (ADDR_W=4): arm with THRESH=0, then 20 ticks -> exactly 16 writes (addr 0..15), full=1, length=16, done pulses once. Remaining ticks produce no ram_wren.
6. Abort and ignore: arm then stop in ARMED -> no done, length keeps its prior value (4). A second arm while busy has no effect. arm and stop together in IDLE -> enters ARMED.
